// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default bus widths,
// FSM state encoding and a small decode helper.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_PORTS  = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_CAPTURE = 3'd2,
        ST_WR         = 3'd3,
        ST_ACK        = 3'd4
    } arb_state_t;

    function automatic logic is_read_state(input arb_state_t s);
        return (s == ST_RD_ISSUE) || (s == ST_RD_CAPTURE);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester-side handshakes plus memory strobes/address of the arbiter.
// The bidirectional memory data bus is kept as a plain inout on the top.
import memory_arbiter_pkg::*;

interface memory_arbiter_if #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              P0_REQ;
    logic              P0_WE;
    logic [ADDR_W-1:0] P0_ADDR;
    logic [DATA_W-1:0] P0_WDATA;
    logic              P0_ACK;
    logic [DATA_W-1:0] P0_RDATA;

    logic              P1_REQ;
    logic              P1_WE;
    logic [ADDR_W-1:0] P1_ADDR;
    logic [DATA_W-1:0] P1_WDATA;
    logic              P1_ACK;
    logic [DATA_W-1:0] P1_RDATA;

    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;

    modport master (
        output P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
        input  P0_ACK, P0_RDATA,
        output P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
        input  P1_ACK, P1_RDATA,
        input  MEM_READ, MEM_WRITE, MEM_ADDR
    );

    modport slave (
        input  P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
        output P0_ACK, P0_RDATA,
        input  P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
        output P1_ACK, P1_RDATA,
        output MEM_READ, MEM_WRITE, MEM_ADDR
    );
endinterface

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant. A lone request always wins; on contention the
// port not granted last wins. The pointer moves only when a grant is taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_take,
    input  logic [1:0] i_req,
    output logic       o_gnt_idx
);
    // Port preferred on the next contended grant; port 0 out of reset.
    logic r_prio;

    always_comb begin
        o_gnt_idx = 1'b0;
        case (i_req)
            2'b10:   o_gnt_idx = 1'b1;
            2'b11:   o_gnt_idx = r_prio;
            default: o_gnt_idx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_take && (|i_req)) begin
            r_prio <= ~o_gnt_idx;
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter onto a single-cycle-strobe memory with a shared tristate
// data bus. Reads take RD_ISSUE + RD_CAPTURE, writes one WR cycle, then ACK.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    memory_arbiter_if.slave   bus,
    inout  wire [DATA_W-1:0]  MEM_DATA
);
    arb_state_t        r_state;
    arb_state_t        w_state_next;

    logic              r_sel;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata [NUM_PORTS];

    logic [1:0]        w_req;
    logic              w_gnt_idx;
    logic              w_take;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_ack;
    logic              w_rd_strobe;
    logic              w_wr_strobe;

    assign w_req  = {bus.P1_REQ, bus.P0_REQ};
    assign w_take = (r_state == ST_IDLE) && (|w_req);

    rr_arbiter_2 u_rr (
        .clk       (CLK),
        .rst_n     (RST),
        .i_take    (r_state == ST_IDLE),
        .i_req     (w_req),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_sel_we    = w_gnt_idx ? bus.P1_WE    : bus.P0_WE;
    assign w_sel_addr  = w_gnt_idx ? bus.P1_ADDR  : bus.P0_ADDR;
    assign w_sel_wdata = w_gnt_idx ? bus.P1_WDATA : bus.P0_WDATA;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Requests are only looked at in IDLE, so ACK always returns through IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_next = w_sel_we ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE:   w_state_next = ST_RD_CAPTURE;
            ST_RD_CAPTURE: w_state_next = ST_ACK;
            ST_WR:         w_state_next = ST_ACK;
            ST_ACK:        w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_sel   <= w_gnt_idx;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // Per-port read-data holding register and one-cycle ACK decode.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    r_rdata[gi] <= '0;
                end else if ((r_state == ST_RD_CAPTURE) && (r_sel == 1'(gi)) && !r_we) begin
                    r_rdata[gi] <= MEM_DATA;
                end
            end

            assign w_ack[gi] = (r_state == ST_ACK) && (r_sel == 1'(gi));
        end
    endgenerate

    assign w_rd_strobe = is_read_state(r_state);
    assign w_wr_strobe = (r_state == ST_WR);

    assign bus.P0_ACK    = w_ack[0];
    assign bus.P1_ACK    = w_ack[1];
    assign bus.P0_RDATA  = r_rdata[0];
    assign bus.P1_RDATA  = r_rdata[1];
    assign bus.MEM_READ  = w_rd_strobe;
    assign bus.MEM_WRITE = w_wr_strobe;
    assign bus.MEM_ADDR  = (w_rd_strobe || w_wr_strobe) ? r_addr : '0;
    assign MEM_DATA      = w_wr_strobe ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random
// traffic scored against a reference memory image and a read-data queue.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    wire [DW-1:0] mem_data;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .bus      (bus),
        .MEM_DATA (mem_data)
    );

    // Asynchronous-read memory device on the far side of the arbiter.
    logic [DW-1:0] mem_model [64];
    assign mem_data = bus.MEM_READ ? mem_model[bus.MEM_ADDR[5:0]] : {DW{1'bz}};
    always @(posedge clk) begin
        if (bus.MEM_WRITE) mem_model[bus.MEM_ADDR[5:0]] <= mem_data;
    end

    logic [DW-1:0] exp_mem [64];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] last_rd [2];
    int n_cmp = 0;
    int n_err = 0;

    task automatic drive_port(input int p, input logic req, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.P0_REQ = req; bus.P0_WE = we; bus.P0_ADDR = a; bus.P0_WDATA = d;
        end else begin
            bus.P1_REQ = req; bus.P1_WE = we; bus.P1_ADDR = a; bus.P1_WDATA = d;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? bus.P0_ACK : bus.P1_ACK;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int p);
        return (p == 0) ? bus.P0_RDATA : bus.P1_RDATA;
    endfunction

    // Every cycle advance also checks strobe exclusivity and ACK exclusivity.
    task automatic tick();
        @(negedge clk);
        n_cmp++;
        if ((bus.MEM_READ && bus.MEM_WRITE) || (bus.P0_ACK && bus.P1_ACK)) begin
            n_err++;
            $display("FAIL exclusivity: rd=%0b wr=%0b ack0=%0b ack1=%0b required no overlap",
                     bus.MEM_READ, bus.MEM_WRITE, bus.P0_ACK, bus.P1_ACK);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic do_txn(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int lat;
        logic got;
        logic [DW-1:0] exp;
        drive_port(p, 1'b1, we, a, d);
        if (we) exp_mem[a[5:0]] = d;
        else    sb_q.push_back(exp_mem[a[5:0]]);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            tick();
            lat++;
            if (get_ack(p)) got = 1'b1;
        end
        n_cmp++;
        if (!got || lat != (we ? 2 : 3)) begin
            n_err++;
            $display("FAIL txn_latency p%0d we=%0b: got=%0b lat=%0d required %0d",
                     p, we, got, lat, we ? 2 : 3);
        end
        if (!we) begin
            exp = sb_q.pop_front();
            n_cmp++;
            if (get_rdata(p) !== exp) begin
                n_err++;
                $display("FAIL read_data p%0d addr=%0h: got %08h required %08h",
                         p, a, get_rdata(p), exp);
            end
            last_rd[p] = exp;
        end else begin
            n_cmp++;
            if (get_rdata(p) !== last_rd[p]) begin
                n_err++;
                $display("FAIL rdata_hold p%0d: got %08h required %08h",
                         p, get_rdata(p), last_rd[p]);
            end
        end
        $display("txn p%0d %s addr=%0h data=%08h lat=%0d", p, we ? "WR" : "RD", a,
                 we ? d : get_rdata(p), lat);
        drive_port(p, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_reset();
        drive_port(0, 1'b1, 1'b1, 26'h5, 32'h1234_5678);
        drive_port(1, 1'b1, 1'b0, 26'h6, '0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.P0_ACK, bus.P1_ACK, bus.MEM_READ, bus.MEM_WRITE} !== 4'b0000 ||
                bus.MEM_ADDR !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: ack0=%0b ack1=%0b rd=%0b wr=%0b addr=%0h required all 0",
                         bus.P0_ACK, bus.P1_ACK, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR);
            end
        end
        n_cmp++;
        if (bus.P0_RDATA !== '0 || bus.P1_RDATA !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: p0=%08h p1=%08h required 0", bus.P0_RDATA, bus.P1_RDATA);
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        tick();
        n_cmp++;
        if ({bus.P0_ACK, bus.P1_ACK, bus.MEM_READ, bus.MEM_WRITE} !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_idle: strobes/acks=%04b required 0000",
                     {bus.P0_ACK, bus.P1_ACK, bus.MEM_READ, bus.MEM_WRITE});
        end
        $display("reset checked");
    endtask

    task automatic test_write();
        drive_port(0, 1'b1, 1'b1, 26'h10, 32'hDEAD_BEEF);
        exp_mem[6'h10] = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if (bus.MEM_WRITE !== 1'b1 || bus.MEM_READ !== 1'b0 || bus.MEM_ADDR !== 26'h10 ||
            mem_data !== 32'hDEAD_BEEF || bus.P0_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL write_cycle: wr=%0b rd=%0b addr=%0h data=%08h ack=%0b required 1 0 10 deadbeef 0",
                     bus.MEM_WRITE, bus.MEM_READ, bus.MEM_ADDR, mem_data, bus.P0_ACK);
        end
        tick();
        n_cmp++;
        if (bus.P0_ACK !== 1'b1 || bus.P1_ACK !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin
            n_err++;
            $display("FAIL write_ack: ack0=%0b ack1=%0b wr=%0b required 1 0 0",
                     bus.P0_ACK, bus.P1_ACK, bus.MEM_WRITE);
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        tick();
        n_cmp++;
        if (bus.P0_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL write_ack_pulse: ack0=%0b required 0", bus.P0_ACK);
        end
        $display("txn p0 WR addr=10 data=deadbeef");
    endtask

    task automatic test_read();
        logic [DW-1:0] exp;
        drive_port(1, 1'b1, 1'b0, 26'h10, '0);
        sb_q.push_back(exp_mem[6'h10]);
        tick();
        n_cmp++;
        if (bus.MEM_READ !== 1'b1 || bus.MEM_WRITE !== 1'b0 || bus.MEM_ADDR !== 26'h10 ||
            bus.P1_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL read_issue: rd=%0b wr=%0b addr=%0h ack1=%0b required 1 0 10 0",
                     bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR, bus.P1_ACK);
        end
        tick();
        n_cmp++;
        if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDR !== 26'h10 || bus.P1_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL read_capture: rd=%0b addr=%0h ack1=%0b required 1 10 0",
                     bus.MEM_READ, bus.MEM_ADDR, bus.P1_ACK);
        end
        tick();
        exp = sb_q.pop_front();
        n_cmp++;
        if (bus.P1_ACK !== 1'b1 || bus.MEM_READ !== 1'b0 || bus.P1_RDATA !== exp) begin
            n_err++;
            $display("FAIL read_ack: ack1=%0b rd=%0b rdata=%08h required 1 0 %08h",
                     bus.P1_ACK, bus.MEM_READ, bus.P1_RDATA, exp);
        end
        last_rd[1] = exp;
        drive_port(1, 1'b0, 1'b0, '0, '0);
        tick();
        n_cmp++;
        if (bus.P1_RDATA !== exp || bus.P1_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL read_hold: rdata=%08h ack1=%0b required %08h 0",
                     bus.P1_RDATA, bus.P1_ACK, exp);
        end
        $display("txn p1 RD addr=10 data=%08h", bus.P1_RDATA);
    endtask

    task automatic test_both();
        int ack_port [$];
        int ack_tick [$];
        int t;
        do_reset(2);
        tick();
        drive_port(0, 1'b1, 1'b1, 26'h20, 32'hAAAA_0000);
        drive_port(1, 1'b1, 1'b1, 26'h21, 32'h5555_1111);
        exp_mem[6'h20] = 32'hAAAA_0000;
        exp_mem[6'h21] = 32'h5555_1111;
        t = 0;
        while (ack_port.size() < 3 && t < 30) begin
            tick();
            t++;
            if (bus.P0_ACK) begin ack_port.push_back(0); ack_tick.push_back(t); end
            if (bus.P1_ACK) begin ack_port.push_back(1); ack_tick.push_back(t); end
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (ack_port.size() != 3) begin
            n_err++;
            $display("FAIL rr_ack_count: got %0d acks required 3", ack_port.size());
        end else begin
            n_cmp++;
            if (ack_port[0] != 0 || ack_port[1] != 1 || ack_port[2] != 0) begin
                n_err++;
                $display("FAIL rr_order: got %0d,%0d,%0d required 0,1,0",
                         ack_port[0], ack_port[1], ack_port[2]);
            end
            n_cmp++;
            if (ack_tick[0] != 2 || ack_tick[1] != 5 || ack_tick[2] != 8) begin
                n_err++;
                $display("FAIL rr_timing: ack cycles %0d,%0d,%0d required 2,5,8",
                         ack_tick[0], ack_tick[1], ack_tick[2]);
            end
            $display("round-robin acks p%0d@%0d p%0d@%0d p%0d@%0d", ack_port[0], ack_tick[0],
                     ack_port[1], ack_tick[1], ack_port[2], ack_tick[2]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_txn(0, 1'b0, 26'h10, '0);
        drive_port(0, 1'b1, 1'b0, 26'h20, '0);
        tick();
        tick();
        n_cmp++;
        if (bus.MEM_READ !== 1'b1 || bus.P0_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_capture: rd=%0b ack0=%0b required 1 0", bus.MEM_READ, bus.P0_ACK);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.P0_ACK, bus.P1_ACK, bus.MEM_READ, bus.MEM_WRITE} !== 4'b0000 ||
                bus.P0_RDATA !== '0 || bus.MEM_ADDR !== '0) begin
                n_err++;
                $display("FAIL midrst_abandon: acks/strobes=%04b rdata0=%08h addr=%0h required 0000 0 0",
                         {bus.P0_ACK, bus.P1_ACK, bus.MEM_READ, bus.MEM_WRITE},
                         bus.P0_RDATA, bus.MEM_ADDR);
            end
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.P0_ACK !== 1'b0 || bus.MEM_READ !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_no_ack: ack0=%0b rd=%0b required 0 0", bus.P0_ACK, bus.MEM_READ);
            end
        end
        $display("reset during RD_CAPTURE abandoned read");
    endtask

    task automatic test_rerequest();
        drive_port(0, 1'b1, 1'b1, 26'h30, 32'hC0FF_EE00);
        exp_mem[6'h30] = 32'hC0FF_EE00;
        tick();
        tick();
        n_cmp++;
        if (bus.P0_ACK !== 1'b1) begin
            n_err++;
            $display("FAIL rereq_first_ack: ack0=%0b required 1", bus.P0_ACK);
        end
        drive_port(0, 1'b1, 1'b1, 26'h31, 32'h0BAD_F00D);
        exp_mem[6'h31] = 32'h0BAD_F00D;
        tick();
        n_cmp++;
        if ({bus.P0_ACK, bus.MEM_READ, bus.MEM_WRITE} !== 3'b000) begin
            n_err++;
            $display("FAIL rereq_turnaround: ack/rd/wr=%03b required 000",
                     {bus.P0_ACK, bus.MEM_READ, bus.MEM_WRITE});
        end
        tick();
        n_cmp++;
        if (bus.MEM_WRITE !== 1'b1 || bus.MEM_ADDR !== 26'h31 || mem_data !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL rereq_grant: wr=%0b addr=%0h data=%08h required 1 31 0badf00d",
                     bus.MEM_WRITE, bus.MEM_ADDR, mem_data);
        end
        tick();
        n_cmp++;
        if (bus.P0_ACK !== 1'b1) begin
            n_err++;
            $display("FAIL rereq_second_ack: ack0=%0b required 1", bus.P0_ACK);
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        tick();
        $display("txn p0 WR addr=31 after re-request");
    endtask

    task automatic test_back_to_back();
        int p;
        logic we;
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) begin
            do_txn(int'($urandom_range(0, 1)), 1'b1, AW'(i), DW'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            p  = int'($urandom_range(0, 1));
            we = ($urandom_range(0, 2) == 0);
            a  = AW'($urandom_range(0, 15));
            do_txn(p, we, a, DW'($urandom));
        end
        do_txn(0, 1'b0, 26'h30, '0);
        do_txn(1, 1'b0, 26'h31, '0);
        do_txn(0, 1'b0, 26'h21, '0);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
        end
    endtask

    initial begin
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_reset_mid();
        test_rerequest();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
